// File: rtl/latch_out_debouncer.sv
// Synchroniser + two-state debounce FSM for a latch Q output: clean level, edge strobes, saturating counters.
// Optional feature: define DEBOUNCE_GLITCH_CNT_EN to add the glitch_cnt output (aborted qualifications).
module latch_out_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_in,
    input  logic             clr_cnt,
    output logic             q_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             cnt_sat
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [CNT_W-1:0] glitch_cnt
`endif
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {ST_STABLE, ST_PENDING} state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] w_sync_d;
    state_t                 r_state;
    logic [DB_W-1:0]        r_db_cnt;
    logic                   r_q_out;
    logic                   r_rise;
    logic                   r_fall;
    logic [CNT_W-1:0]       r_edge_cnt;
    logic                   w_s;
    logic                   w_diff;
    logic                   w_flip;
    logic                   w_abort;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign w_sync_d[gi] = d_in;
            end else begin : g_rest
                assign w_sync_d[gi] = r_sync[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= w_sync_d;
        end
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_diff = (w_s != r_q_out);
    // A single-cycle debounce accepts straight from STABLE; otherwise only the last PENDING count flips.
    assign w_flip = w_diff && (((r_state == ST_STABLE) && (DEBOUNCE_CYCLES == 1)) ||
                               ((r_state == ST_PENDING) && (r_db_cnt == DB_LAST)));
    assign w_abort = (r_state == ST_PENDING) && !w_diff;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_STABLE;
            r_db_cnt   <= '0;
            r_q_out    <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_edge_cnt <= '0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                ST_STABLE: begin
                    if (w_diff && (DEBOUNCE_CYCLES != 1)) begin
                        r_state  <= ST_PENDING;
                        r_db_cnt <= DB_W'(1);
                    end
                end
                ST_PENDING: begin
                    if (!w_diff || w_flip) begin
                        r_state  <= ST_STABLE;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + DB_W'(1);
                    end
                end
                default: begin
                    r_state  <= ST_STABLE;
                    r_db_cnt <= '0;
                end
            endcase
            if (w_flip) begin
                r_q_out <= w_s;
                r_rise  <= w_s;
                r_fall  <= !w_s;
            end
            if (clr_cnt) begin
                r_edge_cnt <= '0;
            end else if (w_flip && (r_edge_cnt != CNT_MAX)) begin
                r_edge_cnt <= r_edge_cnt + CNT_W'(1);
            end
        end
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [CNT_W-1:0] r_glitch_cnt;

    always_ff @(posedge clk) begin
        if (reset || clr_cnt) begin
            r_glitch_cnt <= '0;
        end else if (w_abort && (r_glitch_cnt != CNT_MAX)) begin
            r_glitch_cnt <= r_glitch_cnt + CNT_W'(1);
        end
    end

    assign glitch_cnt = r_glitch_cnt;
`else
    logic w_abort_unused;
    assign w_abort_unused = w_abort;
`endif

    assign q_out      = r_q_out;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;
    assign edge_cnt   = r_edge_cnt;
    assign cnt_sat    = (r_edge_cnt == CNT_MAX);

endmodule
